// File: rtl/ibus_arb.sv
// ibus_arb: two-master / one-slave arbiter for the femto req/resp bus.
// m0 is the core fetch unit, m1 the debug/DMA loader. One transaction is
// outstanding on the slave side at a time; a request that cannot be forwarded
// in its own cycle is parked in that master's pending slot and issued later.
//
// Handshake: every *_req is a single-cycle pulse with its payload valid in the
// same cycle. A transaction ends with either a resp pulse (slave completed) or
// a fault pulse (s_fault seen in the grant cycle). A master may pulse a new req
// in the same cycle as its own resp, but not earlier.
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module ibus_arb #(
   parameter logic RR_EN = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst,
   // master 0
   input  logic                              m0_req,
   input  logic [`XLEN-1:0]                  m0_addr,
   input  logic                              m0_w_rb,
   input  logic [$clog2(`BUS_ACC_CNT)-1:0]   m0_acc,
   input  logic [`BUS_WIDTH-1:0]             m0_wdata,
   output logic                              m0_resp,
   output logic [`BUS_WIDTH-1:0]             m0_rdata,
   output logic                              m0_fault,
   // master 1
   input  logic                              m1_req,
   input  logic [`XLEN-1:0]                  m1_addr,
   input  logic                              m1_w_rb,
   input  logic [$clog2(`BUS_ACC_CNT)-1:0]   m1_acc,
   input  logic [`BUS_WIDTH-1:0]             m1_wdata,
   output logic                              m1_resp,
   output logic [`BUS_WIDTH-1:0]             m1_rdata,
   output logic                              m1_fault,
   // slave side
   output logic                              s_req,
   output logic [`XLEN-1:0]                  s_addr,
   output logic                              s_w_rb,
   output logic [$clog2(`BUS_ACC_CNT)-1:0]   s_acc,
   output logic [`BUS_WIDTH-1:0]             s_wdata,
   input  logic                              s_resp,
   input  logic [`BUS_WIDTH-1:0]             s_rdata,
   input  logic                              s_fault,
   // status
   output logic                              arb_err,
   output logic                              o_dbg_state
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_WAIT = 1'b1;

   logic                              r_state;
   logic                              r_owner;
   logic                              r_last;
   logic                              r_arb_err;

   logic                              r_pend0;
   logic [`XLEN-1:0]                  r_addr0;
   logic                              r_w_rb0;
   logic [$clog2(`BUS_ACC_CNT)-1:0]   r_acc0;
   logic [`BUS_WIDTH-1:0]             r_wdata0;

   logic                              r_pend1;
   logic [`XLEN-1:0]                  r_addr1;
   logic                              r_w_rb1;
   logic [$clog2(`BUS_ACC_CNT)-1:0]   r_acc1;
   logic [`BUS_WIDTH-1:0]             r_wdata1;

   logic w_idle;
   logic w_cand0;
   logic w_cand1;
   logic w_grant_vld;
   logic w_grant;
   logic w_fwd0;
   logic w_fwd1;
   logic w_cap0;
   logic w_cap1;
   logic w_done;
   logic w_viol;

   assign w_idle  = (r_state == S_IDLE);
   // A parked request and a live pulse both make a master a candidate.
   assign w_cand0 = r_pend0 | m0_req;
   assign w_cand1 = r_pend1 | m1_req;
   assign w_grant_vld = w_idle & (w_cand0 | w_cand1);

   // Pick the winner: on a tie, round-robin favours the master not served last.
   always_comb begin
      w_grant = w_cand1;
      if (w_cand0 && w_cand1) begin
         if (RR_EN) w_grant = ~r_last;
         else       w_grant = 1'b0;
      end
   end

   // A live pulse is forwarded only when its master wins with an empty slot;
   // otherwise the pending slot takes precedence and the pulse is parked.
   assign w_fwd0 = w_grant_vld & ~w_grant & ~r_pend0;
   assign w_fwd1 = w_grant_vld &  w_grant & ~r_pend1;
   assign w_cap0 = m0_req & ~w_fwd0;
   assign w_cap1 = m1_req & ~w_fwd1;

   assign w_done = ~w_idle & s_resp;

   // Protocol violations: overwriting a full slot, the owner re-requesting
   // before its resp, or a slave resp with nothing outstanding.
   assign w_viol = (m0_req & r_pend0) | (m1_req & r_pend1)
                 | (~w_idle & ~s_resp & ((m0_req & ~r_owner) | (m1_req & r_owner)))
                 | (w_idle & s_resp);

   // Route the granted payload to the slave; m0 live inputs when nothing is granted.
   always_comb begin
      s_addr  = m0_addr;
      s_w_rb  = m0_w_rb;
      s_acc   = m0_acc;
      s_wdata = m0_wdata;
      if (w_grant_vld && w_grant) begin
         if (r_pend1) begin
            s_addr  = r_addr1;
            s_w_rb  = r_w_rb1;
            s_acc   = r_acc1;
            s_wdata = r_wdata1;
         end else begin
            s_addr  = m1_addr;
            s_w_rb  = m1_w_rb;
            s_acc   = m1_acc;
            s_wdata = m1_wdata;
         end
      end else if (w_grant_vld && r_pend0) begin
         s_addr  = r_addr0;
         s_w_rb  = r_w_rb0;
         s_acc   = r_acc0;
         s_wdata = r_wdata0;
      end
   end

   // Strobes are forced low while rst is held so reset silences the bus at once.
   assign s_req    = w_grant_vld & ~rst;
   assign m0_fault = w_grant_vld & s_fault & ~w_grant & ~rst;
   assign m1_fault = w_grant_vld & s_fault &  w_grant & ~rst;
   assign m0_resp  = w_done & ~r_owner & ~rst;
   assign m1_resp  = w_done &  r_owner & ~rst;
   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign arb_err  = r_arb_err;
   assign o_dbg_state = r_state;

   // Arbitration FSM: IDLE grants, WAIT holds until the slave responds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_owner <= w_grant;
                  r_last  <= w_grant;
                  if (!s_fault) r_state <= S_WAIT;
               end
            end
            default: begin
               if (s_resp) r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Pending valid bits: set by an unforwarded pulse, cleared when the slot is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend0 <= 1'b0;
         r_pend1 <= 1'b0;
      end else begin
         r_pend0 <= w_cap0 | (r_pend0 & ~(w_grant_vld & ~w_grant));
         r_pend1 <= w_cap1 | (r_pend1 & ~(w_grant_vld &  w_grant));
      end
   end

   // Pending payload buffers; a newer pulse always overwrites the slot.
   always_ff @(posedge clk) begin
      if (w_cap0) begin
         r_addr0  <= m0_addr;
         r_w_rb0  <= m0_w_rb;
         r_acc0   <= m0_acc;
         r_wdata0 <= m0_wdata;
      end
      if (w_cap1) begin
         r_addr1  <= m1_addr;
         r_w_rb1  <= m1_w_rb;
         r_acc1   <= m1_acc;
         r_wdata1 <= m1_wdata;
      end
   end

   // Sticky protocol-violation flag, cleared only by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_arb_err <= 1'b0;
      else if (w_viol) r_arb_err <= 1'b1;
   end

endmodule

// File: doc/ibus_arb.md
Name: ibus_arb

Overview:
- Two-master, one-slave arbiter on the femto req/resp bus.
- Shares the instruction-side interconnect port between the core fetch unit (m0) and a debug/DMA loader (m1).
- Output drives the m_* side of the slave interconnect and its bus_fault line.
- One outstanding transaction on the slave side; the losing master's request is buffered, never dropped.

Parameters:
- RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, m0 wins.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  m0 request pulse, one cycle per transaction
- m0_addr  in  `XLEN  m0 address
- m0_w_rb  in  1  m0 write (1) / read (0)
- m0_acc  in  $clog2(`BUS_ACC_CNT)  m0 access size
- m0_wdata  in  `BUS_WIDTH  m0 write data
- m0_resp  out  1  m0 completion pulse
- m0_rdata  out  `BUS_WIDTH  m0 read data
- m0_fault  out  1  m0 decode-fault pulse
- m1_*  same set as m0_*, for master 1
- s_req  out  1  slave request pulse
- s_addr  out  `XLEN  slave address
- s_w_rb  out  1  slave write/read select
- s_acc  out  $clog2(`BUS_ACC_CNT)  slave access size
- s_wdata  out  `BUS_WIDTH  slave write data
- s_resp  in  1  slave completion pulse, at least 1 cycle after s_req
- s_rdata  in  `BUS_WIDTH  slave read data
- s_fault  in  1  combinational "no slave selected" for the current s_req
- arb_err  out  1  sticky protocol-violation flag

Behaviour:
- Protocol:
  - Masters pulse req for one cycle, with addr/w_rb/acc/wdata valid in that cycle.
  - Masters issue no further req until resp or fault, except in the resp cycle itself.
- State:
  - FSM has two states, IDLE and WAIT.
  - Registers: owner (1 bit), last (1 bit); per master a pending valid bit plus an addr/w_rb/acc/wdata buffer.
- Candidates in IDLE:
  - Candidate for master i = pend_i | mi_req.
  - For each master, a valid pending slot has precedence over its live req; a live req at that point is a violation.
- Grant in IDLE:
  - No candidate: s_req = 0.
  - One candidate: grant it.
  - Two candidates with RR_EN=1: grant ~last.
  - Two candidates with RR_EN=0: grant m0.
  - Granted master's payload (pending buffer or live inputs) drives s_* combinationally; s_req = 1 in the same cycle, so a live req has 0-cycle latency.
  - Set owner = last = granted master; clear its pending bit.
  - If s_fault = 1 in that cycle: pulse mi_fault the same cycle and stay in IDLE. Otherwise go to WAIT.
- Capture rule: every mi_req not forwarded in its own cycle is latched into pending slot i on the next edge. This applies in both IDLE and WAIT, including a req coincident with its own resp.
- In WAIT:
  - s_req = 0.
  - On s_resp: m{owner}_resp = 1 in the same cycle, then go to IDLE. The next grant is issued the following cycle, a 1-cycle turnaround.
  - s_resp while in IDLE is ignored and sets arb_err.
- Read data: m0_rdata = m1_rdata = s_rdata, pass-through. Masters sample only on their own resp.
- Idle s_* payload: when s_req = 0, s_* carries m0 live inputs; the value is don't-care.
- Violations (each sets arb_err, which stays set until rst):
  - req arriving while the same master's pending slot is valid; the new payload overwrites the slot.
  - req from the owner while in WAIT before resp.
- Reset:
  - Asynchronous, to IDLE; owner = 0; last = 1, so m0 wins the first tie.
  - Pending bits = 0; arb_err = 0; s_req / mi_resp / mi_fault = 0.
  - Reset mid-transaction drops the outstanding and pending transactions; the slave is reset by the same rst.

Test Plan:
- Single m0 read: m0_req at addr 0x0000_0100, slave resp 2 cycles later with rdata 0xDEADBEEF -> s_req in the same cycle as m0_req; m0_resp=1 and m0_rdata=0xDEADBEEF in the resp cycle; m1_resp stays 0.
- Simultaneous m0/m1 req, RR_EN=1, after reset -> m0 granted first; m1 payload buffered; m1 s_req asserted exactly 1 cycle after m0_resp with m1's addr/wdata unchanged; next tie goes to m1.
- Same as above with RR_EN=0, repeated 3 times -> m0 wins every tie; m1 is served after each m0 completion.
- m1_req arrives mid-WAIT of m0 (addr 0x2000_0000, write, wdata 0x12345678) -> slot captured; issued after m0_resp with w_rb=1 and wdata 0x12345678.
- Granted req with s_fault=1 -> m0_fault pulses the same cycle; no resp; FSM remains IDLE; next req granted immediately.
- Back-to-back m0 req while its pending slot is full, and stray s_resp while idle -> arb_err rises and holds; rst asserted mid-WAIT -> all outputs 0 asynchronously; arb_err cleared.
